// File: rtl/dds_spi_master_if.sv
// Command/status bus between the DDS APB register block (master) and the
// SPI engine (slave).
interface dds_spi_master_if;
  logic        Start;
  logic        WR;
  logic [31:0] DataOut;
  logic        Busy;
  logic [31:0] DataIn;

  modport master (output Start, WR, DataOut, input Busy, DataIn);
  modport slave  (input Start, WR, DataOut, output Busy, DataIn);
endinterface

// File: rtl/dds_spi_master.sv
// 32-bit mode-0 SPI frame engine for the external DDS chip.
// Define DDS_SPI_IO_UPDATE_EN to follow write frames with an IO_UPDATE pulse.
module dds_spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned UPDATE_W = 4
) (
  input  logic            APB_0_axiclk,
  input  logic            APB_0_aresetn,
  dds_spi_master_if.slave bus,
  output logic            dds_sclk,
  output logic            dds_csn,
  output logic            dds_sdo,
  input  logic            dds_sdi,
  output logic            dds_io_update
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned WORD_W = 32;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 255 || UPDATE_W < 1 || UPDATE_W > 255) begin : g_bad_cfg
    $error("dds_spi_master: CLK_DIV and UPDATE_W must be in 1..255");
  end

`ifdef DDS_SPI_IO_UPDATE_EN
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_UPDATE} state_e;
  localparam logic [CNT_W-1:0] UPD_LAST = CNT_W'(UPDATE_W - 1);
  logic upd_q, upd_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [WORD_W-1:0]  rxreg_q, rxreg_d;
  logic [WORD_W-1:0]  datain_q, datain_d;
  logic               wr_q, wr_d;
  logic               busy_q, busy_d;
  logic               sclk_q, sclk_d;
  logic               csn_q, csn_d;
  logic               div_done_c;

  // Next-state and output logic; every register holds by default.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    rxreg_d  = rxreg_q;
    datain_d = datain_q;
    wr_d     = wr_q;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    csn_d    = csn_q;
`ifdef DDS_SPI_IO_UPDATE_EN
    upd_d    = upd_q;
`endif
    div_done_c = (cnt_q == DIV_LAST);

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          shreg_d = bus.DataOut;
          wr_d    = bus.WR;
          busy_d  = 1'b1;
          csn_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (div_done_c) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_SHIFT: begin
        if (div_done_c) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rxreg_d = {rxreg_q[WORD_W-2:0], dds_sdi};
            bit_d   = bit_q + 5'd1;
          end else if (bit_q == '0) begin
            // Bit counter wrapped on the 32nd rising edge: this is the last
            // falling edge, so the line keeps the final bit through HOLD.
            state_d = S_HOLD;
          end else begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (div_done_c) begin
          cnt_d = '0;
          csn_d = 1'b1;
`ifdef DDS_SPI_IO_UPDATE_EN
          if (wr_q) begin
            upd_d   = 1'b1;
            state_d = S_UPDATE;
          end else begin
            datain_d = rxreg_q;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end
`else
          if (!wr_q) begin
            datain_d = rxreg_q;
          end
          busy_d  = 1'b0;
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

`ifdef DDS_SPI_IO_UPDATE_EN
      S_UPDATE: begin
        if (cnt_q == UPD_LAST) begin
          cnt_d   = '0;
          upd_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge APB_0_axiclk or negedge APB_0_aresetn) begin
    if (!APB_0_aresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      rxreg_q  <= '0;
      datain_q <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      csn_q    <= 1'b1;
`ifdef DDS_SPI_IO_UPDATE_EN
      upd_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      rxreg_q  <= rxreg_d;
      datain_q <= datain_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      sclk_q   <= sclk_d;
      csn_q    <= csn_d;
`ifdef DDS_SPI_IO_UPDATE_EN
      upd_q    <= upd_d;
`endif
    end
  end

  // The shift register MSB is the registered serial data pin.
  assign dds_sdo    = shreg_q[WORD_W-1];
  assign dds_sclk   = sclk_q;
  assign dds_csn    = csn_q;
  assign bus.Busy   = busy_q;
  assign bus.DataIn = datain_q;
`ifdef DDS_SPI_IO_UPDATE_EN
  assign dds_io_update = upd_q;
`else
  assign dds_io_update = 1'b0;
`endif

endmodule

// File: tb/tb_dds_spi_master.sv
// Bench for dds_spi_master: three instances with different dividers, a
// line-level monitor/slave model and a frame-level reference model.
module tb_dds_spi_master;

  localparam int N = 3;

`ifdef DDS_SPI_IO_UPDATE_EN
  localparam bit UPD_EN = 1'b1;
`else
  localparam bit UPD_EN = 1'b0;
`endif

  function automatic int unsigned div_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned uw_of(input int g);
    case (g)
      0:       return 4;
      1:       return 2;
      default: return 5;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start [N];
  logic        wr    [N];
  logic [31:0] dout  [N];
  logic        busy  [N];
  logic [31:0] din   [N];
  logic        sclk  [N];
  logic        csn   [N];
  logic        sdo   [N];
  logic        sdi   [N];
  logic        upd   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    dds_spi_master_if bus ();
    assign bus.Start   = start[g];
    assign bus.WR      = wr[g];
    assign bus.DataOut = dout[g];
    assign busy[g]     = bus.Busy;
    assign din[g]      = bus.DataIn;

    dds_spi_master #(.CLK_DIV(div_of(g)), .UPDATE_W(uw_of(g))) u_dut (
      .APB_0_axiclk (clk),
      .APB_0_aresetn(rst_n),
      .bus          (bus),
      .dds_sclk     (sclk[g]),
      .dds_csn      (csn[g]),
      .dds_sdo      (sdo[g]),
      .dds_sdi      (sdi[g]),
      .dds_io_update(upd[g])
    );
  end

  // Line monitor and DDS read-back model, sampled on the falling clock edge.
  logic [31:0] sdi_word  [N];
  logic [31:0] sdo_word  [N];
  logic [31:0] last_word [N];
  logic        prev_sclk [N];
  logic        prev_csn  [N];
  int          sdi_idx   [N];
  int unsigned bits_now  [N];
  int unsigned last_bits [N];
  int unsigned frames    [N];
  int unsigned busy_run  [N];
  int unsigned busy_len  [N];
  int unsigned gap_run   [N];
  int unsigned gap_len   [N];
  int unsigned upd_cyc   [N];
  int unsigned upd_bad   [N];

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (!rst_n) begin
        prev_sclk[g] <= 1'b0;
        prev_csn[g]  <= 1'b1;
        sdi[g]       <= 1'b0;
        sdi_idx[g]   <= -1;
        bits_now[g]  <= 0;
        frames[g]    <= 0;
        busy_run[g]  <= 0;
        gap_run[g]   <= 0;
        upd_cyc[g]   <= 0;
        upd_bad[g]   <= 0;
        sdo_word[g]  <= '0;
      end else begin
        if (busy[g]) busy_run[g] <= busy_run[g] + 1;
        else if (busy_run[g] != 0) begin
          busy_len[g] <= busy_run[g];
          busy_run[g] <= 0;
        end
        if (csn[g]) gap_run[g] <= gap_run[g] + 1;
        else if (gap_run[g] != 0) begin
          gap_len[g] <= gap_run[g];
          gap_run[g] <= 0;
        end
        if (upd[g]) begin
          upd_cyc[g] <= upd_cyc[g] + 1;
          if (!csn[g]) upd_bad[g] <= upd_bad[g] + 1;
        end
        if (prev_csn[g] && !csn[g]) begin
          sdo_word[g] <= '0;
          bits_now[g] <= 0;
          sdi[g]      <= sdi_word[g][31];
          sdi_idx[g]  <= 30;
        end
        if (!prev_sclk[g] && sclk[g]) begin
          sdo_word[g] <= {sdo_word[g][30:0], sdo[g]};
          bits_now[g] <= bits_now[g] + 1;
        end
        if (prev_sclk[g] && !sclk[g] && !csn[g] && sdi_idx[g] >= 0) begin
          sdi[g]     <= sdi_word[g][5'(sdi_idx[g])];
          sdi_idx[g] <= sdi_idx[g] - 1;
        end
        if (!prev_csn[g] && csn[g]) begin
          last_word[g] <= sdo_word[g];
          last_bits[g] <= bits_now[g];
          frames[g]    <= frames[g] + 1;
        end
        prev_sclk[g] <= sclk[g];
        prev_csn[g]  <= csn[g];
      end
    end
  end

  int unsigned passes = 0;
  int unsigned fails  = 0;
  int unsigned checks = 0;
  logic [31:0] din_model [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int g, input logic w, input logic [31:0] data);
    start[g] = 1'b1;
    wr[g]    = w;
    dout[g]  = data;
    @(negedge clk);
    #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (busy[g] === 1'b1 && n < 80 * div_of(g) + 300);
    check($sformatf("g%0d_idle_timeout", g), 32'(busy[g]), 32'd0);
  endtask

  task automatic wait_bits(input int g, input int unsigned nb);
    int unsigned n;
    n = 0;
    while (bits_now[g] < nb && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("g%0d_reach_bit%0d", g, nb), 32'(bits_now[g]), 32'(nb));
  endtask

  // Frame-level expectations: word on the line, Busy length, pulse width, DataIn.
  task automatic check_frame(input int g, input logic w, input logic [31:0] data,
                             input int unsigned f0, input int unsigned u0, input int unsigned b0);
    int unsigned eu, eb;
    logic [31:0] ed;
    eu = 0;
    if (w && UPD_EN) eu = uw_of(g);
    eb = 66 * div_of(g) + eu;
    ed = w ? din_model[g] : sdi_word[g];
    check($sformatf("g%0d_sdo_word", g),  last_word[g], data);
    check($sformatf("g%0d_sclk_bits", g), 32'(last_bits[g]), 32'd32);
    check($sformatf("g%0d_busy_len", g),  32'(busy_len[g]), 32'(eb));
    check($sformatf("g%0d_frames", g),    32'(frames[g] - f0), 32'd1);
    check($sformatf("g%0d_upd_len", g),   32'(upd_cyc[g] - u0), 32'(eu));
    check($sformatf("g%0d_upd_csn", g),   32'(upd_bad[g] - b0), 32'd0);
    check($sformatf("g%0d_datain", g),    din[g], ed);
    din_model[g] = ed;
  endtask

  task automatic run_frame(input int g, input logic w, input logic [31:0] data, input logic [31:0] rx);
    int unsigned f0, u0, b0;
    f0 = frames[g];
    u0 = upd_cyc[g];
    b0 = upd_bad[g];
    sdi_word[g] = rx;
    pulse_start(g, w, data);
    wait_idle(g);
    check_frame(g, w, data, f0, u0, b0);
  endtask

  task automatic check_reset_outs(input int g, input string when);
    check($sformatf("g%0d_%s_busy", g, when), 32'(busy[g]), 32'd0);
    check($sformatf("g%0d_%s_sclk", g, when), 32'(sclk[g]), 32'd0);
    check($sformatf("g%0d_%s_csn", g, when),  32'(csn[g]),  32'd1);
    check($sformatf("g%0d_%s_sdo", g, when),  32'(sdo[g]),  32'd0);
    check($sformatf("g%0d_%s_upd", g, when),  32'(upd[g]),  32'd0);
    check($sformatf("g%0d_%s_din", g, when),  din[g],       32'd0);
  endtask

  initial begin
    int unsigned f0, u0, b0;
    rst_n = 1'b0;
    for (int g = 0; g < N; g++) begin
      start[g]     = 1'b0;
      wr[g]        = 1'b0;
      dout[g]      = '0;
      sdi_word[g]  = '0;
      din_model[g] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < N; g++) check_reset_outs(g, "por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Directed write and read on the CLK_DIV=2 instance.
    run_frame(0, 1'b1, 32'h01A5_5A3C, $urandom);
    run_frame(0, 1'b0, 32'h8100_0000, 32'hDEAD_BEEF);

    // Start while busy must be dropped without disturbing the frame.
    f0 = frames[0];
    u0 = upd_cyc[0];
    b0 = upd_bad[0];
    sdi_word[0] = $urandom;
    pulse_start(0, 1'b1, 32'h1234_5678);
    wait_bits(0, 5);
    pulse_start(0, 1'b0, 32'hFFFF_FFFF);
    wait_idle(0);
    check_frame(0, 1'b1, 32'h1234_5678, f0, u0, b0);
    repeat (8 * div_of(0)) @(negedge clk);
    #1;
    check("collision_single_frame", 32'(frames[0] - f0), 32'd1);
    check("collision_idle_after", 32'(busy[0]), 32'd0);

    // Randomized frames on every instance.
    for (int g = 0; g < N; g++) begin
      for (int k = 0; k < 3; k++) begin
        run_frame(g, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end

    // Back-to-back reads at CLK_DIV=1: one idle clock with csn high between.
    run_frame(1, 1'b0, $urandom, $urandom);
    run_frame(1, 1'b0, $urandom, $urandom);
    check("b2b_csn_gap", 32'(gap_len[1]), 32'd1);

    // Write frame at CLK_DIV=3.
    run_frame(2, 1'b1, $urandom, $urandom);

    // Reset in the middle of a shift aborts the frame immediately.
    sdi_word[0] = $urandom;
    pulse_start(0, 1'b1, $urandom);
    wait_bits(0, 10);
    rst_n = 1'b0;
    #1;
    check_reset_outs(0, "midrst");
    @(negedge clk);
    #1;
    check("midrst_no_update", 32'(upd[0]), 32'd0);
    rst_n = 1'b1;
    for (int g = 0; g < N; g++) din_model[g] = '0;
    repeat (2) @(negedge clk);
    #1;
    run_frame(0, 1'b0, $urandom, $urandom);
    run_frame(0, 1'b1, $urandom, $urandom);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dds_spi_master.md
Name: dds_spi_master

Overview:
- Serial-port engine directly downstream of the DDS APB register block.
- Consumes the `Start`/`WR`/`DataOut` command and returns `Busy`/`DataIn`.
- Runs one 32-bit SPI frame (mode 0, MSB first) to the external DDS chip; on write frames, follows with an `IO_UPDATE` pulse.
- Single clock domain; the chip-side pins are registered outputs.

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal range 1..255.
- UPDATE_W, 4: width of the `dds_io_update` pulse in clocks; legal range 1..255.

Ports:
- APB_0_axiclk  in  1  system clock (all logic on rising edge).
- APB_0_aresetn  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle command pulse from the register block.
- WR  in  1  frame type: 1 = write, 0 = read.
- DataOut  in  32  frame word shifted to the DDS (instruction byte plus data).
- Busy  out  1  high while a frame or update pulse is in progress.
- DataIn  out  32  word captured from `dds_sdi` on the last read frame.
- dds_sclk  out  1  serial clock, idles low.
- dds_csn  out  1  chip select, active low.
- dds_sdo  out  1  serial data to the DDS.
- dds_sdi  in  1  serial data from the DDS, already synchronous to the system clock.
- dds_io_update  out  1  DDS register-transfer strobe.

Behaviour:
- Reset values: `Busy`=0, `DataIn`=0, `dds_sclk`=0, `dds_csn`=1, `dds_sdo`=0, `dds_io_update`=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame at once: all outputs return to their reset values and no update pulse is issued.
- FSM states: IDLE, SETUP, SHIFT, HOLD, UPDATE.
- IDLE:
  - `Start`=1 is accepted; `DataOut` and `WR` are latched into `shreg`/`wr_q` on the same edge.
  - Next cycle: `Busy`=1, `dds_csn`=0, `dds_sdo`=`DataOut[31]`, FSM goes to SETUP.
- `Start` while `Busy`=1 is ignored with no queueing; latched `shreg`/`wr_q` are unaffected.
- SETUP:
  - Lasts CLK_DIV clocks with `dds_sclk` low, then goes to SHIFT.
- SHIFT:
  - Half-period counter counts CLK_DIV clocks.
  - Each expiry toggles `dds_sclk`.
  - On a rising toggle: shift `dds_sdi` into `rxreg` LSB (MSB-first assembly) and increment the bit counter (0..31).
  - On a falling toggle: shift `shreg` left and drive the new bit 31 on `dds_sdo`.
  - After the 32nd falling edge go to HOLD, with `dds_sclk` low and `dds_sdo` holding its last value.
- HOLD:
  - Lasts CLK_DIV clocks with `dds_csn`=0, then `dds_csn`=1.
  - If `wr_q`=0: `DataIn` <= `rxreg`, then go to IDLE.
  - If `wr_q`=1: `DataIn` is unchanged, then go to UPDATE.
- UPDATE:
  - `dds_io_update`=1 for UPDATE_W clocks while `dds_csn`=1, then IDLE.
- IDLE entry: `Busy`=0 on the same edge the FSM returns to IDLE.
- `Busy` high duration:
  - Write frame: 66*CLK_DIV + UPDATE_W clocks.
  - Read frame: 66*CLK_DIV clocks.
- `Start` can be accepted on the first cycle `Busy`=0, so back-to-back frames are separated by exactly one IDLE cycle with `dds_csn`=1.
- Bit counter is 5 bits wide and wraps 31->0 only at the SHIFT exit; the half-period and update counters are 8 bits wide.
- SCLK frequency = f_clk / (2*CLK_DIV). With CLK_DIV=1, SCLK toggles every clock.

Optional Feature:
- Macro `DDS_SPI_IO_UPDATE_EN`.
- Defined: behaviour as above; write frames end with the UPDATE pulse.
- Undefined:
  - UPDATE state is removed; HOLD always returns to IDLE.
  - `dds_io_update` is tied to 0.
  - Write-frame `Busy` duration is 66*CLK_DIV clocks.
  - Read-frame behaviour is identical with or without the macro.

Test Plan:
- Reset: assert reset mid-SHIFT at bit 10 -> `dds_csn`=1, `dds_sclk`=0, `Busy`=0 immediately; after release a new `Start` completes normally.
- Write, macro on, CLK_DIV=2, UPDATE_W=4:
  - Stimulus: `DataOut`=0x01A5_5A3C, `WR`=1, `Start` pulse.
  - Required: `dds_sdo` sampled on 32 rising `dds_sclk` edges equals 0x01A55A3C MSB first.
  - Required: `Busy` high 136 clocks; `dds_io_update` high 4 clocks after `dds_csn` rises; `DataIn` unchanged.
- Read, CLK_DIV=2:
  - Stimulus: `WR`=0, `DataOut`=0x8100_0000; bench model drives `dds_sdi` with 0xDEADBEEF MSB first on falling edges.
  - Required: `DataIn`=0xDEADBEEF after the frame; `Busy` high 132 clocks; `dds_io_update` stays 0.
- Busy collision: second `Start` with `DataOut`=0xFFFFFFFF at bit 5 of a frame sending 0x12345678 -> ignored; the line still carries 0x12345678 and only one frame is seen.
- Back-to-back: `Start` on the first cycle `Busy`=0 -> `dds_csn` high exactly 1 clock between frames; CLK_DIV=1 gives SCLK = f_clk/2 with correct data.
- Macro off, CLK_DIV=3, write frame -> `dds_io_update` never asserts; `Busy` high 198 clocks.
